// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage:
// ALU codes, B-operand selects, opcodes, mul/div states.
package ex_pkg;

   localparam logic [5:0] ALU_SLL   = 6'h00;
   localparam logic [5:0] ALU_SRL   = 6'h02;
   localparam logic [5:0] ALU_SRA   = 6'h03;
   localparam logic [5:0] ALU_SLLV  = 6'h04;
   localparam logic [5:0] ALU_SRLV  = 6'h06;
   localparam logic [5:0] ALU_SRAV  = 6'h07;
   localparam logic [5:0] ALU_LUI   = 6'h0F;
   localparam logic [5:0] ALU_MFHI  = 6'h10;
   localparam logic [5:0] ALU_MTHI  = 6'h11;
   localparam logic [5:0] ALU_MFLO  = 6'h12;
   localparam logic [5:0] ALU_MTLO  = 6'h13;
   localparam logic [5:0] ALU_MULT  = 6'h18;
   localparam logic [5:0] ALU_MULTU = 6'h19;
   localparam logic [5:0] ALU_DIV   = 6'h1A;
   localparam logic [5:0] ALU_DIVU  = 6'h1B;
   localparam logic [5:0] ALU_ADD   = 6'h20;
   localparam logic [5:0] ALU_ADDU  = 6'h21;
   localparam logic [5:0] ALU_SUB   = 6'h22;
   localparam logic [5:0] ALU_SUBU  = 6'h23;
   localparam logic [5:0] ALU_AND   = 6'h24;
   localparam logic [5:0] ALU_OR    = 6'h25;
   localparam logic [5:0] ALU_XOR   = 6'h26;
   localparam logic [5:0] ALU_NOR   = 6'h27;
   localparam logic [5:0] ALU_SLT   = 6'h2A;
   localparam logic [5:0] ALU_SLTU  = 6'h2B;

   localparam logic [2:0] SRC_P2   = 3'd0;
   localparam logic [2:0] SRC_SIMM = 3'd1;
   localparam logic [2:0] SRC_ZIMM = 3'd2;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } md_state_t;

   function automatic logic is_mul(
      input logic [5:0] op
   );
      return (op == ALU_MULT) ||
             (op == ALU_MULTU);
   endfunction

   function automatic logic is_div(
      input logic [5:0] op
   );
      return (op == ALU_DIV) ||
             (op == ALU_DIVU);
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO.
// Restoring divider, one quotient bit per cycle.
module ex_muldiv
   import ex_pkg::*;
#(
   parameter int MUL_LAT  = 4,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        valid_i,
   input  logic [5:0]  alu_op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        stall_o,
   output md_state_t   state_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int CW = $clog2(DIV_ITER + 1);

   md_state_t     state;
   logic [CW-1:0] cnt;
   logic [31:0]   opa;
   logic [31:0]   opb;
   logic [32:0]   rem;
   logic          mul_sgn;
   logic          div_op;
   logic          neg_q;
   logic          neg_r;
   logic [31:0]   hi;
   logic [31:0]   lo;

   logic          idle;
   logic          start_mul;
   logic          start_div;
   logic          sdiv;
   logic          mt_ok;
   logic [63:0]   a_ext;
   logic [63:0]   b_ext;
   logic [63:0]   prod;
   logic [32:0]   shifted;
   logic [33:0]   trial;
   logic [31:0]   q_fix;
   logic [31:0]   r_fix;

   assign idle      = (state == IDLE);
   assign start_mul = idle & valid_i & ~clr &
                      is_mul(alu_op_i);
   assign start_div = idle & valid_i & ~clr &
                      is_div(alu_op_i);
   assign sdiv      = (alu_op_i == ALU_DIV);

   assign stall_o = ~clr &
                    (start_mul | start_div |
                     (state == MUL) |
                     (state == DIV));

   assign mt_ok = valid_i & ~stall_o & ~clr;

   // Sign/zero extension makes one 64-bit
   // product serve MULT and MULTU alike.
   always_comb begin
      a_ext = {32'b0, opa};
      b_ext = {32'b0, opb};
      if (mul_sgn) begin
         a_ext = {{32{opa[31]}}, opa};
         b_ext = {{32{opb[31]}}, opb};
      end
      prod = a_ext * b_ext;
   end

   // One restoring step plus the final sign fix-ups.
   always_comb begin
      shifted = {rem[31:0], opa[31]};
      trial   = {1'b0, shifted} - {2'b0, opb};
      q_fix   = neg_q ? -opa : opa;
      r_fix   = neg_r ? -rem[31:0] : rem[31:0];
      if (opb == 32'b0) begin
         q_fix = 32'hFFFF_FFFF;
      end
   end

   // Mul/div sequencing, operand capture and HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         opa     <= '0;
         opb     <= '0;
         rem     <= '0;
         mul_sgn <= 1'b0;
         div_op  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else if (clr) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_mul) begin
                  opa     <= a_i;
                  opb     <= b_i;
                  mul_sgn <= (alu_op_i == ALU_MULT);
                  div_op  <= 1'b0;
                  cnt     <= CW'(MUL_LAT - 1);
                  state   <= MUL;
               end else if (start_div) begin
                  opa <= (sdiv & a_i[31]) ?
                         -a_i : a_i;
                  opb <= (sdiv & b_i[31]) ?
                         -b_i : b_i;
                  neg_q  <= sdiv & (a_i[31] ^ b_i[31]);
                  neg_r  <= sdiv & a_i[31];
                  rem    <= '0;
                  div_op <= 1'b1;
                  cnt    <= CW'(DIV_ITER);
                  state  <= DIV;
               end else if (mt_ok) begin
                  if (alu_op_i == ALU_MTHI) hi <= a_i;
                  if (alu_op_i == ALU_MTLO) lo <= a_i;
               end
            end
            MUL: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DIV: begin
               if (trial[33]) begin
                  rem <= shifted;
                  opa <= {opa[30:0], 1'b0};
               end else begin
                  rem <= trial[32:0];
                  opa <= {opa[30:0], 1'b1};
               end
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               if (div_op) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end else begin
                  hi <= prod[63:32];
                  lo <= prod[31:0];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign state_o = state;
   assign hi_o    = hi;
   assign lo_o    = lo;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, shifter, branch/JR resolution,
// mispredict redirect and the mul/div unit.
module ex_stage
   import ex_pkg::*;
#(
   parameter int MUL_LAT  = 4,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        valid_i,
   input  logic [5:0]  op_i,
   input  logic        jump_i,
   input  logic        branch_i,
   input  logic        reg_wr_i,
   input  logic        mem_to_reg_i,
   input  logic        mem_wr_i,
   input  logic        reg_dst_i,
   input  logic        use_link_reg_i,
   input  logic        brn_pred_i,
   input  logic [5:0]  alu_op_i,
   input  logic [2:0]  alu_src_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] r_data_p1_i,
   input  logic [31:0] r_data_p2_i,
   input  logic [31:0] sign_imm_i,
   input  logic [31:0] brn_eq_pc_i,
   input  logic [31:0] curr_pc_i,
   input  logic [31:0] next_pred_pc_i,
   input  logic [31:0] next_seq_pc_i,
   input  logic [4:0]  shamt_i,
   output logic        stall_o,
   output logic        valid_o,
   output logic        reg_wr_o,
   output logic        mem_to_reg_o,
   output logic        mem_wr_o,
   output logic [4:0]  wr_reg_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] st_data_o,
   output logic        mispredict_o,
   output logic [31:0] redirect_pc_o
);

   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_res;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] actual_pc;
   logic        br_take;
   logic        unused_ok;
   md_state_t   md_state;

   ex_muldiv #(
      .MUL_LAT  (MUL_LAT),
      .DIV_ITER (DIV_ITER)
   ) u_md (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .valid_i  (valid_i),
      .alu_op_i (alu_op_i),
      .a_i      (r_data_p1_i),
      .b_i      (r_data_p2_i),
      .stall_o  (stall_o),
      .state_o  (md_state),
      .hi_o     (hi),
      .lo_o     (lo)
   );

   assign a = r_data_p1_i;

   // B-operand selection.
   always_comb begin
      case (alu_src_i)
         SRC_P2:   b = r_data_p2_i;
         SRC_SIMM: b = sign_imm_i;
         SRC_ZIMM: b = {16'b0, sign_imm_i[15:0]};
         default:  b = 32'b0;
      endcase
   end

   // Combinational ALU and shifter, wrap-around.
   always_comb begin
      case (alu_op_i)
         ALU_ADD,
         ALU_ADDU: alu_res = a + b;
         ALU_SUB,
         ALU_SUBU: alu_res = a - b;
         ALU_AND:  alu_res = a & b;
         ALU_OR:   alu_res = a | b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_NOR:  alu_res = ~(a | b);
         ALU_SLT:  alu_res = {31'b0,
                      $signed(a) < $signed(b)};
         ALU_SLTU: alu_res = {31'b0, a < b};
         ALU_SLL:  alu_res = b << shamt_i;
         ALU_SRL:  alu_res = b >> shamt_i;
         ALU_SRA:  alu_res = 32'($signed(b)
                      >>> shamt_i);
         ALU_SLLV: alu_res = b << a[4:0];
         ALU_SRLV: alu_res = b >> a[4:0];
         ALU_SRAV: alu_res = 32'($signed(b)
                      >>> a[4:0]);
         ALU_LUI:  alu_res = {b[15:0], 16'b0};
         ALU_MFHI: alu_res = hi;
         ALU_MFLO: alu_res = lo;
         default:  alu_res = 32'b0;
      endcase
   end

   assign br_take = branch_i &
      (((op_i == OP_BEQ) & (a == r_data_p2_i)) |
       ((op_i == OP_BNE) & (a != r_data_p2_i)));

   // Resolve the architecturally correct next PC.
   always_comb begin
      if (br_take)
         actual_pc = brn_eq_pc_i;
      else if (jump_i && op_i == OP_SPECIAL)
         actual_pc = a;
      else if (jump_i)
         actual_pc = next_pred_pc_i;
      else
         actual_pc = next_seq_pc_i;
   end

   assign valid_o = valid_i & ~stall_o & ~clr;

   assign reg_wr_o     = reg_wr_i & valid_o;
   assign mem_to_reg_o = mem_to_reg_i & valid_o;
   assign mem_wr_o     = mem_wr_i & valid_o;

   assign wr_reg_o = use_link_reg_i ? 5'd31 :
                     reg_dst_i      ? rd_i  : rt_i;

   assign alu_result_o = use_link_reg_i ?
                         next_seq_pc_i : alu_res;
   assign st_data_o    = r_data_p2_i;

   assign mispredict_o  = valid_o &
                          (actual_pc != next_pred_pc_i);
   assign redirect_pc_o = actual_pc;

   assign unused_ok = ^{curr_pc_i, brn_pred_i,
                        md_state};

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_ex_stage;
   import ex_pkg::*;

   logic        clk;
   logic        reset;
   logic        clr;
   logic        valid_i;
   logic [5:0]  op_i;
   logic        jump_i;
   logic        branch_i;
   logic        reg_wr_i;
   logic        mem_to_reg_i;
   logic        mem_wr_i;
   logic        reg_dst_i;
   logic        use_link_reg_i;
   logic        brn_pred_i;
   logic [5:0]  alu_op_i;
   logic [2:0]  alu_src_i;
   logic [4:0]  rt_i;
   logic [4:0]  rd_i;
   logic [31:0] r_data_p1_i;
   logic [31:0] r_data_p2_i;
   logic [31:0] sign_imm_i;
   logic [31:0] brn_eq_pc_i;
   logic [31:0] curr_pc_i;
   logic [31:0] next_pred_pc_i;
   logic [31:0] next_seq_pc_i;
   logic [4:0]  shamt_i;
   logic        stall_o;
   logic        valid_o;
   logic        reg_wr_o;
   logic        mem_to_reg_o;
   logic        mem_wr_o;
   logic [4:0]  wr_reg_o;
   logic [31:0] alu_result_o;
   logic [31:0] st_data_o;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;

   int n_assert = 0;
   int n_fail   = 0;
   int n;

   ex_stage dut (
      .clk            (clk),
      .reset          (reset),
      .clr            (clr),
      .valid_i        (valid_i),
      .op_i           (op_i),
      .jump_i         (jump_i),
      .branch_i       (branch_i),
      .reg_wr_i       (reg_wr_i),
      .mem_to_reg_i   (mem_to_reg_i),
      .mem_wr_i       (mem_wr_i),
      .reg_dst_i      (reg_dst_i),
      .use_link_reg_i (use_link_reg_i),
      .brn_pred_i     (brn_pred_i),
      .alu_op_i       (alu_op_i),
      .alu_src_i      (alu_src_i),
      .rt_i           (rt_i),
      .rd_i           (rd_i),
      .r_data_p1_i    (r_data_p1_i),
      .r_data_p2_i    (r_data_p2_i),
      .sign_imm_i     (sign_imm_i),
      .brn_eq_pc_i    (brn_eq_pc_i),
      .curr_pc_i      (curr_pc_i),
      .next_pred_pc_i (next_pred_pc_i),
      .next_seq_pc_i  (next_seq_pc_i),
      .shamt_i        (shamt_i),
      .stall_o        (stall_o),
      .valid_o        (valid_o),
      .reg_wr_o       (reg_wr_o),
      .mem_to_reg_o   (mem_to_reg_o),
      .mem_wr_o       (mem_wr_o),
      .wr_reg_o       (wr_reg_o),
      .alu_result_o   (alu_result_o),
      .st_data_o      (st_data_o),
      .mispredict_o   (mispredict_o),
      .redirect_pc_o  (redirect_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic idle_in;
      clr            = 1'b0;
      valid_i        = 1'b0;
      op_i           = '0;
      jump_i         = 1'b0;
      branch_i       = 1'b0;
      reg_wr_i       = 1'b0;
      mem_to_reg_i   = 1'b0;
      mem_wr_i       = 1'b0;
      reg_dst_i      = 1'b0;
      use_link_reg_i = 1'b0;
      brn_pred_i     = 1'b0;
      alu_op_i       = '0;
      alu_src_i      = '0;
      rt_i           = '0;
      rd_i           = '0;
      r_data_p1_i    = '0;
      r_data_p2_i    = '0;
      sign_imm_i     = '0;
      brn_eq_pc_i    = '0;
      curr_pc_i      = '0;
      next_pred_pc_i = '0;
      next_seq_pc_i  = '0;
      shamt_i        = '0;
   endtask

   // Issue a mul/div op and count stall cycles.
   task automatic run_md(
      input string       tag,
      input logic [5:0]  op,
      input logic [31:0] a,
      input logic [31:0] b,
      input int          exp_stall
   );
      cyc;
      idle_in;
      valid_i     = 1'b1;
      alu_op_i    = op;
      r_data_p1_i = a;
      r_data_p2_i = b;
      n = 0;
      smp;
      while (stall_o && n < 100) begin
         n++;
         smp;
      end
      chk({tag, "_stall"}, n, exp_stall);
      chk({tag, "_retire"}, {31'b0, valid_o}, 1);
   endtask

   // Read back HI and LO via MFHI/MFLO.
   task automatic rd_hilo(
      input string       tag,
      input logic [31:0] exp_hi,
      input logic [31:0] exp_lo
   );
      cyc;
      idle_in;
      valid_i  = 1'b1;
      reg_wr_i = 1'b1;
      alu_op_i = ALU_MFLO;
      smp;
      chk({tag, "_lo"}, alu_result_o, exp_lo);
      cyc;
      alu_op_i = ALU_MFHI;
      smp;
      chk({tag, "_hi"}, alu_result_o, exp_hi);
   endtask

   initial begin
      idle_in;
      reset = 1'b1;
      alu_op_i = ALU_MFHI;
      smp;
      chk("rst_stall", {31'b0, stall_o}, 0);
      chk("rst_valid", {31'b0, valid_o}, 0);
      chk("rst_hi", alu_result_o, 0);
      cyc;
      reset = 1'b0;

      // ADD overflow wraps, no trap.
      cyc;
      idle_in;
      valid_i        = 1'b1;
      reg_wr_i       = 1'b1;
      alu_op_i       = ALU_ADD;
      alu_src_i      = SRC_SIMM;
      r_data_p1_i    = 32'h7FFF_FFFF;
      sign_imm_i     = 32'h1;
      next_pred_pc_i = 32'h104;
      next_seq_pc_i  = 32'h104;
      rt_i           = 5'd9;
      smp;
      chk("add_res", alu_result_o, 32'h8000_0000);
      chk("add_valid", {31'b0, valid_o}, 1);
      chk("add_stall", {31'b0, stall_o}, 0);
      chk("add_regwr", {31'b0, reg_wr_o}, 1);
      chk("add_wrreg", {27'b0, wr_reg_o}, 9);
      chk("add_nomisp", {31'b0, mispredict_o}, 0);

      // SRA keeps the sign.
      cyc;
      alu_op_i    = ALU_SRA;
      alu_src_i   = SRC_P2;
      r_data_p2_i = 32'hF000_0000;
      shamt_i     = 5'd4;
      smp;
      chk("sra_res", alu_result_o, 32'hFF00_0000);
      chk("st_data", st_data_o, 32'hF000_0000);

      // Zero-extended immediate into OR, LUI.
      cyc;
      alu_op_i    = ALU_OR;
      alu_src_i   = SRC_ZIMM;
      r_data_p1_i = 32'h0000_0001;
      sign_imm_i  = 32'hFFFF_8000;
      smp;
      chk("ori_res", alu_result_o, 32'h0000_8001);
      cyc;
      alu_op_i = ALU_LUI;
      smp;
      chk("lui_res", alu_result_o, 32'h8000_0000);

      // SLT signed vs SLTU unsigned.
      cyc;
      alu_op_i    = ALU_SLT;
      alu_src_i   = SRC_P2;
      r_data_p1_i = 32'hFFFF_FFFF;
      r_data_p2_i = 32'h1;
      smp;
      chk("slt_res", alu_result_o, 1);
      cyc;
      alu_op_i = ALU_SLTU;
      smp;
      chk("sltu_res", alu_result_o, 0);

      // Bubble gates write enables.
      cyc;
      valid_i  = 1'b0;
      mem_wr_i = 1'b1;
      smp;
      chk("bub_regwr", {31'b0, reg_wr_o}, 0);
      chk("bub_memwr", {31'b0, mem_wr_o}, 0);

      // BEQ taken, predicted not taken.
      cyc;
      idle_in;
      valid_i        = 1'b1;
      branch_i       = 1'b1;
      op_i           = OP_BEQ;
      r_data_p1_i    = 32'd5;
      r_data_p2_i    = 32'd5;
      next_pred_pc_i = 32'h104;
      next_seq_pc_i  = 32'h104;
      brn_eq_pc_i    = 32'h200;
      smp;
      chk("beq_misp", {31'b0, mispredict_o}, 1);
      chk("beq_redir", redirect_pc_o, 32'h200);
      cyc;
      brn_pred_i     = 1'b1;
      next_pred_pc_i = 32'h200;
      smp;
      chk("beq_ok", {31'b0, mispredict_o}, 0);

      // BNE not taken but predicted taken.
      cyc;
      op_i = OP_BNE;
      smp;
      chk("bne_misp", {31'b0, mispredict_o}, 1);
      chk("bne_redir", redirect_pc_o, 32'h104);

      // JALR to register target with link.
      cyc;
      idle_in;
      valid_i        = 1'b1;
      jump_i         = 1'b1;
      reg_wr_i       = 1'b1;
      use_link_reg_i = 1'b1;
      reg_dst_i      = 1'b1;
      rd_i           = 5'd5;
      alu_op_i       = ALU_ADD;
      r_data_p1_i    = 32'h400;
      next_pred_pc_i = 32'h108;
      next_seq_pc_i  = 32'h108;
      smp;
      chk("jalr_misp", {31'b0, mispredict_o}, 1);
      chk("jalr_redir", redirect_pc_o, 32'h400);
      chk("jalr_wrreg", {27'b0, wr_reg_o}, 31);
      chk("jalr_res", alu_result_o, 32'h108);
      cyc;
      use_link_reg_i = 1'b0;
      smp;
      chk("rd_wrreg", {27'b0, wr_reg_o}, 5);

      // Multiply / divide.
      run_md("mult", ALU_MULT, 32'hFFFF_FFFD, 32'd7, 4);
      rd_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_md("multu", ALU_MULTU, 32'hFFFF_FFFF,
             32'd2, 4);
      rd_hilo("multu", 32'h1, 32'hFFFF_FFFE);
      run_md("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 33);
      rd_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divmin", ALU_DIV, 32'h8000_0000,
             32'hFFFF_FFFF, 33);
      rd_hilo("divmin", 32'h0, 32'h8000_0000);
      run_md("divu0", ALU_DIVU, 32'd10, 32'd0, 33);
      rd_hilo("divu0", 32'd10, 32'hFFFF_FFFF);

      // MTHI / MTLO.
      cyc;
      idle_in;
      valid_i     = 1'b1;
      alu_op_i    = ALU_MTHI;
      r_data_p1_i = 32'h1234_5678;
      cyc;
      alu_op_i    = ALU_MTLO;
      r_data_p1_i = 32'h9ABC_DEF0;
      rd_hilo("mt", 32'h1234_5678, 32'h9ABC_DEF0);
      run_md("divu", ALU_DIVU, 32'd10, 32'd0, 33);

      // Flush a DIV in its tenth stall cycle.
      cyc;
      idle_in;
      valid_i     = 1'b1;
      alu_op_i    = ALU_DIV;
      r_data_p1_i = 32'd100;
      r_data_p2_i = 32'd7;
      smp;
      chk("clr_busy", {31'b0, stall_o}, 1);
      repeat (9) cyc;
      clr = 1'b1;
      smp;
      chk("clr_stall", {31'b0, stall_o}, 0);
      chk("clr_valid", {31'b0, valid_o}, 0);
      cyc;
      clr     = 1'b0;
      valid_i = 1'b0;
      smp;
      chk("clr_idle", {30'b0, dut.u_md.state},
          {30'b0, IDLE});
      rd_hilo("clr", 32'd10, 32'hFFFF_FFFF);
      cyc;
      alu_op_i    = ALU_ADD;
      r_data_p1_i = 32'd3;
      r_data_p2_i = 32'd4;
      smp;
      chk("post_add", alu_result_o, 32'd7);
      chk("post_valid", {31'b0, valid_o}, 1);
      chk("post_stall", {31'b0, stall_o}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
